// File: rtl/encrypt_pkg.sv
// rtl/encrypt_pkg.sv - shared types and constants for the encrypt pipe controller
// Purpose: controller state encoding, alphabet size, default key width and
//          the width of the outstanding-byte counter.
// Ports:   none (package)
package encrypt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  localparam int ALPHA_N = 26;
  localparam int KEY_W   = 5;
  // Wide enough for the largest supported credit limit (15).
  localparam int CNT_W   = 4;

endpackage

// File: rtl/encrypt_ctrl_credit_cnt.sv
// rtl/encrypt_ctrl_credit_cnt.sv - up/down count of bytes issued but not yet returned
// Purpose: tracks bytes in flight through the encrypt pipe and flags full/empty/underflow.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   inc       in   a byte was issued to the pipe head this cycle
//   dec       in   a byte returned at the pipe tail this cycle
//   full      out  count has reached MAX_OUTST
//   empty     out  count is zero
//   underflow out  return seen with nothing outstanding (and no issue alongside)
module encrypt_ctrl_credit_cnt
  import encrypt_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic underflow
);

  logic [CNT_W-1:0] count;

  assign empty     = (count == '0);
  assign full      = (count >= CNT_W'(MAX_OUTST));
  assign underflow = dec && !inc && empty;

  // Simultaneous issue and return cancel; a return with nothing in flight
  // leaves the count pinned at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/encrypt_pipe_ctrl.sv
// rtl/encrypt_pipe_ctrl.sv - frame sequencer feeding the encrypt shift pipeline
// Purpose: accepts one frame config, streams cfg_len source bytes into the pipe
//          under a credit limit, holds frame settings stable, and pulses done
//          once every issued byte has come back from the pipe tail.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   cfg_valid/cfg_ready            config handshake
//   cfg_mode/shift_en/key/len      frame settings latched on config accept
//   abort                          ends the current frame early
//   s_valid/s_ready/s_data         source byte stream
//   pipe_en/pipe_din               registered byte strobe and byte to pipe head
//   pipe_mode/shift_en/key         frame settings, stable for the frame
//   pipe_ret                       one pulse per byte leaving the pipe tail
//   busy, done, aborted, err       status (err is sticky until next config)
module encrypt_pipe_ctrl
  import encrypt_pkg::*;
#(
  parameter int LEN_W     = 8,
  parameter int KEY_W     = encrypt_pkg::KEY_W,
  parameter int MAX_OUTST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_mode,
  input  logic             cfg_shift_en,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             pipe_en,
  output logic [7:0]       pipe_din,
  output logic             pipe_mode,
  output logic             pipe_shift_en,
  output logic [KEY_W-1:0] pipe_key,
  input  logic             pipe_ret,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err
);

  ctrl_state_t      state, state_nxt;
  logic [LEN_W-1:0] remain;
  logic             abort_seen;
  logic             full, empty, underflow;
  logic             cfg_take, issue;

  // Readies depend only on state and counters, never on the valids.
  assign cfg_ready = (state == IDLE);
  assign s_ready   = (state == RUN) && (remain != '0) && !full;
  assign busy      = (state != IDLE);
  assign cfg_take  = cfg_valid && cfg_ready;
  // Abort wins over a same-cycle handshake: that byte is not taken.
  assign issue     = s_valid && s_ready && !abort;

  encrypt_ctrl_credit_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (issue),
    .dec       (pipe_ret),
    .full      (full),
    .empty     (empty),
    .underflow (underflow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid) state_nxt = (cfg_len == '0) ? DONE : RUN;
      RUN:     if (abort || (issue && remain == LEN_W'(1))) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remain        <= '0;
      abort_seen    <= 1'b0;
      pipe_en       <= 1'b0;
      pipe_din      <= '0;
      pipe_mode     <= 1'b0;
      pipe_shift_en <= 1'b0;
      pipe_key      <= '0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      err           <= 1'b0;
    end else begin
      pipe_en <= issue;
      if (issue) pipe_din <= s_data;

      // done/aborted are registered off DONE, so they pulse as the
      // controller re-enters IDLE.
      done    <= (state == DONE);
      aborted <= (state == DONE) && abort_seen;

      if (cfg_take) begin
        pipe_mode     <= cfg_mode;
        pipe_shift_en <= cfg_shift_en;
        pipe_key      <= cfg_key;
        remain        <= cfg_len;
        abort_seen    <= 1'b0;
      end else if (issue) begin
        remain <= remain - LEN_W'(1);
      end

      if (state == RUN && abort) abort_seen <= 1'b1;

      // A stray return in the accept cycle still counts as an error.
      if (underflow) begin
        err <= 1'b1;
      end else if (cfg_take) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encrypt_pipe_ctrl.sv
// tb/tb_encrypt_pipe_ctrl.sv - self-checking bench for encrypt_pipe_ctrl
module tb_encrypt_pipe_ctrl;
  import encrypt_pkg::*;

  localparam int MAX_OUTST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0, cfg_ready;
  logic       cfg_mode = 1'b0, cfg_shift_en = 1'b0;
  logic [4:0] cfg_key = '0;
  logic [7:0] cfg_len = '0;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0, s_ready;
  logic [7:0] s_data = '0;
  logic       pipe_en, pipe_mode, pipe_shift_en;
  logic [7:0] pipe_din;
  logic [4:0] pipe_key;
  logic       pipe_ret = 1'b0;
  logic       busy, done, aborted, err;

  encrypt_pipe_ctrl #(
    .LEN_W     (8),
    .KEY_W     (5),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_mode      (cfg_mode),
    .cfg_shift_en  (cfg_shift_en),
    .cfg_key       (cfg_key),
    .cfg_len       (cfg_len),
    .abort         (abort),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .pipe_en       (pipe_en),
    .pipe_din      (pipe_din),
    .pipe_mode     (pipe_mode),
    .pipe_shift_en (pipe_shift_en),
    .pipe_key      (pipe_key),
    .pipe_ret      (pipe_ret),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pe = 0, n_done = 0, n_abd = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is active from accept until its done pulse.
  // It stops taking bytes once all were taken or abort arrives; done follows
  // two edges after it has stopped with nothing in flight (one edge for an
  // empty frame, which never waits on the pipe).
  bit         m_active = 0, m_stopped = 0, m_ab = 0;
  bit         m_pe = 0, m_done = 0, m_abd = 0, m_err = 0;
  bit         m_mode = 0, m_shift = 0;
  logic [4:0] m_key = '0;
  logic [7:0] m_din = '0;
  int         m_remain = 0, m_outst = 0, m_fin = -1, edge_n = 0;

  function automatic bit exp_s_ready();
    return m_active && !m_stopped && (m_remain != 0) && (m_outst < MAX_OUTST);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_stopped = 0; m_ab = 0; m_pe = 0; m_done = 0; m_abd = 0;
      m_err = 0; m_mode = 0; m_shift = 0; m_key = '0; m_din = '0;
      m_remain = 0; m_outst = 0; m_fin = -1;
    end else begin : step
      bit iss;
      bit uf;
      edge_n++;
      iss = s_valid && exp_s_ready() && !abort;
      uf  = pipe_ret && !iss && (m_outst == 0);
      m_pe = iss;
      if (iss) m_din = s_data;
      m_done = 0;
      m_abd  = 0;
      m_outst = m_outst + int'(iss) - int'(pipe_ret && (iss || m_outst > 0));
      if (!m_active) begin
        if (cfg_valid) begin
          m_active = 1; m_mode = cfg_mode; m_shift = cfg_shift_en; m_key = cfg_key;
          m_remain = int'(cfg_len); m_err = 0; m_ab = 0;
          m_stopped = (cfg_len == 0);
          m_fin = (cfg_len == 0) ? edge_n + 1 : -1;
        end
      end else if (edge_n == m_fin) begin
        m_active = 0; m_done = 1; m_abd = m_ab;
      end else if (!m_stopped) begin
        if (abort) begin
          m_stopped = 1; m_ab = 1;
        end else if (iss) begin
          m_remain--;
          if (m_remain == 0) m_stopped = 1;
        end
      end
      if (uf) m_err = 1;
      if (m_active && m_stopped && m_outst == 0 && m_fin < 0) m_fin = edge_n + 2;
    end
  end

  always @(negedge clk) begin
    check_eq("cfg_ready", int'(cfg_ready), int'(!m_active));
    check_eq("busy", int'(busy), int'(m_active));
    check_eq("s_ready", int'(s_ready), int'(exp_s_ready()));
    check_eq("pipe_en", int'(pipe_en), int'(m_pe));
    check_eq("pipe_din", int'(pipe_din), int'(m_din));
    check_eq("pipe_mode", int'(pipe_mode), int'(m_mode));
    check_eq("pipe_shift_en", int'(pipe_shift_en), int'(m_shift));
    check_eq("pipe_key", int'(pipe_key), int'(m_key));
    check_eq("done", int'(done), int'(m_done));
    check_eq("aborted", int'(aborted), int'(m_abd));
    check_eq("err", int'(err), int'(m_err));
    if (pipe_en) n_pe++;
    if (done) n_done++;
    if (done && aborted) n_abd++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    abort     = 1'b0;
    pipe_ret  = 1'b0;
    s_valid   = 1'b0;
  endtask

  task automatic send_cfg(input int len, input int key, input bit mode, input bit sh);
    cfg_len = 8'(len); cfg_key = 5'(key); cfg_mode = mode; cfg_shift_en = sh;
    cfg_valid = 1'b1;
    cyc();
  endtask

  task automatic finish_frame();
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      s_valid  = 1'b1;
      s_data   = 8'($urandom);
      pipe_ret = (m_outst > 0);
      cyc();
    end
    check_eq("frame_end_busy", int'(busy), 0);
    cyc();
    cyc();
  endtask

  initial begin
    repeat (2) cyc();
    check_eq("rst_cfg_ready", int'(cfg_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    rst = 1'b1;
    cyc();

    // Three-byte frame, each byte returned three cycles after issue.
    n_pe = 0; n_done = 0;
    send_cfg(3, 3, 1'b1, 1'b1);
    s_valid = 1'b1; s_data = 8'h61; cyc();
    s_valid = 1'b1; s_data = 8'h62; cyc();
    s_valid = 1'b1; s_data = 8'h63; cyc();
    repeat (3) begin pipe_ret = 1'b1; cyc(); end
    repeat (4) cyc();
    check_eq("abc_pipe_en_count", n_pe, 3);
    check_eq("abc_done_count", n_done, 1);

    // Credit limit with returns withheld.
    n_pe = 0;
    send_cfg(8, 5, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin s_valid = 1'b1; s_data = 8'(i); cyc(); end
    check_eq("credit_stall_count", n_pe, 4);
    check_eq("credit_stall_s_ready", int'(s_ready), 0);
    pipe_ret = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin s_valid = 1'b1; s_data = 8'(i + 16); cyc(); end
    check_eq("credit_one_more", n_pe, 5);
    finish_frame();

    // Empty frame.
    n_pe = 0; n_done = 0;
    send_cfg(0, 1, 1'b0, 1'b1);
    check_eq("len0_busy", int'(busy), 1);
    check_eq("len0_done_early", int'(done), 0);
    cyc();
    check_eq("len0_done", int'(done), 1);
    check_eq("len0_busy_after", int'(busy), 0);
    cyc(); cyc();
    check_eq("len0_no_pipe_en", n_pe, 0);
    check_eq("len0_done_count", n_done, 1);

    // Abort after two of five bytes, two returns pending.
    send_cfg(5, 9, 1'b1, 1'b1);
    s_valid = 1'b1; s_data = 8'h41; cyc();
    s_valid = 1'b1; s_data = 8'h42; cyc();
    n_done = 0; n_abd = 0;
    abort = 1'b1; s_valid = 1'b1; s_data = 8'h43; cyc();
    check_eq("abort_s_ready", int'(s_ready), 0);
    check_eq("abort_byte_not_taken", int'(pipe_en), 0);
    cyc();
    pipe_ret = 1'b1; cyc();
    check_eq("abort_wait_ret", n_done, 0);
    pipe_ret = 1'b1; cyc();
    repeat (3) cyc();
    check_eq("abort_done_count", n_done, 1);
    check_eq("abort_aborted_count", n_abd, 1);

    // Stray return while idle.
    pipe_ret = 1'b1; cyc();
    check_eq("stray_err", int'(err), 1);
    send_cfg(0, 2, 1'b0, 1'b0);
    check_eq("err_cleared", int'(err), 0);
    cyc(); cyc();

    // Reset mid-frame with three bytes outstanding.
    send_cfg(5, 4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin s_valid = 1'b1; s_data = 8'(i + 8'h70); cyc(); end
    rst = 1'b0;
    #1;
    check_eq("midrst_cfg_ready", int'(cfg_ready), 1);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_pipe_key", int'(pipe_key), 0);
    check_eq("midrst_s_ready", int'(s_ready), 0);
    cyc(); cyc();
    rst = 1'b1;
    n_done = 0;
    send_cfg(2, 7, 1'b0, 1'b1);
    s_valid = 1'b1; s_data = 8'h31; cyc();
    s_valid = 1'b1; s_data = 8'h32; cyc();
    pipe_ret = 1'b1; cyc();
    pipe_ret = 1'b1; cyc();
    repeat (4) cyc();
    check_eq("post_rst_done", n_done, 1);
    check_eq("post_rst_err", int'(err), 0);

    // Random traffic: configs, stalls, returns, aborts, stray returns.
    for (int i = 0; i < 3000; i++) begin
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_len      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 10));
      cfg_key      = 5'($urandom_range(0, ALPHA_N - 1));
      cfg_mode     = 1'($urandom);
      cfg_shift_en = 1'($urandom);
      s_valid      = ($urandom_range(0, 3) != 0);
      s_data       = 8'($urandom);
      abort        = ($urandom_range(0, 59) == 0);
      pipe_ret     = ((m_outst > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 99) == 0);
      cyc();
    end
    finish_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
